// File: rtl/hdmi_filter_pkg.sv
// Shared definitions for the HDMI Sobel filter: mode encoding, frame FSM
// states and the processed-region border derivation used by the datapath too.
package hdmi_filter_pkg;

  typedef enum logic [1:0] {
    MODE_PASS    = 2'd0,
    MODE_EDGE    = 2'd1,
    MODE_THRESH  = 2'd2,
    MODE_OVERLAY = 2'd3
  } filt_mode_t;

  typedef enum logic [1:0] {
    ST_BLANK  = 2'd0,
    ST_WARMUP = 2'd1,
    ST_ACTIVE = 2'd2
  } frame_state_t;

  // Border on each side when a region of 'region' pixels/lines is centred in 'active'.
  function automatic int unsigned border_px(input int unsigned active,
                                            input int unsigned region);
    return (active - region) / 2;
  endfunction

endpackage

// File: rtl/edge_filter_ctrl_if.sv
// Video-timing and filter-control bundle between the timing generator / filter
// datapath (master) and edge_filter_ctrl (slave).
interface edge_filter_ctrl_if #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480
);

  localparam int unsigned HW = $clog2(H_ACTIVE);
  localparam int unsigned VW = $clog2(V_ACTIVE);

  logic [HW-1:0] h_pos;
  logic [VW-1:0] v_pos;
  logic [1:0]    mode;
  logic [7:0]    threshold;
  logic          window_valid;
  logic          frame_start;
  logic [7:0]    frame_count;

  modport master (
    output h_pos, v_pos,
    input  mode, threshold, window_valid, frame_start, frame_count
  );

  modport slave (
    input  h_pos, v_pos,
    output mode, threshold, window_valid, frame_start, frame_count
  );

endinterface

// File: rtl/btn_debounce.sv
// Raw button -> 2-flop synchronizer -> stability counter -> one-cycle press
// pulse on the accepted 0->1 transition (release produces nothing).
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_press  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        // Accept the new level; pulse only when it is a press.
        r_stable <= r_sync2;
        r_cnt    <= '0;
        r_press  <= r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/edge_filter_ctrl.sv
// Sobel filter control: debounced mode/threshold buttons, settings committed
// at the frame origin, and the per-frame 3x3 window warm-up FSM.
module edge_filter_ctrl
  import hdmi_filter_pkg::*;
#(
  parameter int unsigned H_ACTIVE        = 640,
  parameter int unsigned V_ACTIVE        = 480,
  parameter int unsigned WIDTH           = 534,
  parameter int unsigned HEIGHT          = 400,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned THRESH_STEP     = 16
) (
  input  logic             pixel_clk,
  input  logic             rst,
  input  logic             btn_mode,
  input  logic             btn_thresh,
  edge_filter_ctrl_if.slave bus
);

  localparam int unsigned HW  = $clog2(H_ACTIVE);
  localparam int unsigned VW  = $clog2(V_ACTIVE);
  localparam int unsigned N_W = border_px(H_ACTIVE, WIDTH);
  localparam int unsigned N_H = border_px(V_ACTIVE, HEIGHT);

  localparam logic [HW-1:0] H_WIN_LO   = HW'(N_W + 2);
  localparam logic [HW-1:0] H_WIN_HI   = HW'(N_W + WIDTH);
  localparam logic [HW-1:0] H_LAST     = HW'(H_ACTIVE - 1);
  localparam logic [VW-1:0] V_TOP      = VW'(N_H);
  localparam logic [VW-1:0] V_PRIMED   = VW'(N_H + 2);
  localparam logic [VW-1:0] V_BOTTOM   = VW'(N_H + HEIGHT);
  localparam logic [VW-1:0] V_LAST     = VW'(V_ACTIVE - 1);
  localparam logic [7:0]    THRESH_INC = 8'(THRESH_STEP);

  logic w_mode_press;
  logic w_thresh_press;
  logic w_origin;
  logic w_in_active;
  logic w_win_cond;

  logic [1:0]   r_pend_mode;
  logic [7:0]   r_pend_thresh;
  logic [1:0]   r_mode;
  logic [7:0]   r_threshold;
  logic         r_frame_start;
  logic [7:0]   r_frame_count;
  logic         r_window_valid;
  frame_state_t r_state;
  frame_state_t w_state_nxt;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk     (pixel_clk),
    .rst     (rst),
    .i_btn   (btn_mode),
    .o_press (w_mode_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_thresh (
    .clk     (pixel_clk),
    .rst     (rst),
    .i_btn   (btn_thresh),
    .o_press (w_thresh_press)
  );

  assign w_origin    = (bus.h_pos == '0) && (bus.v_pos == '0);
  assign w_in_active = (bus.h_pos <= H_LAST) && (bus.v_pos <= V_LAST);

  // Presses accumulate here; a press landing on the origin cycle misses that commit.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      r_pend_mode   <= MODE_PASS;
      r_pend_thresh <= '0;
    end else begin
      if (w_mode_press)   r_pend_mode   <= r_pend_mode + 2'd1;
      if (w_thresh_press) r_pend_thresh <= r_pend_thresh + THRESH_INC;
    end
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      r_mode        <= MODE_PASS;
      r_threshold   <= '0;
      r_frame_start <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_frame_start <= w_origin;
      if (w_origin) begin
        r_mode        <= r_pend_mode;
        r_threshold   <= r_pend_thresh;
        r_frame_count <= r_frame_count + 8'd1;
      end
    end
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_BLANK;
      r_window_valid <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_window_valid <= w_win_cond;
    end
  end

  // Window qualification uses the next state so the priming line itself counts.
  always_comb begin
    w_state_nxt = r_state;
    w_win_cond  = 1'b0;
    if (bus.v_pos < V_TOP) begin
      w_state_nxt = ST_BLANK;
    end else begin
      case (r_state)
        ST_BLANK:  if (bus.v_pos == V_TOP)    w_state_nxt = ST_WARMUP;
        ST_WARMUP: if (bus.v_pos == V_PRIMED) w_state_nxt = ST_ACTIVE;
        ST_ACTIVE: if (bus.v_pos == V_BOTTOM) w_state_nxt = ST_BLANK;
        default:                              w_state_nxt = ST_BLANK;
      endcase
    end
    w_win_cond = (w_state_nxt == ST_ACTIVE) && w_in_active &&
                 (bus.h_pos >= H_WIN_LO) && (bus.h_pos < H_WIN_HI);
  end

  assign bus.mode         = r_mode;
  assign bus.threshold    = r_threshold;
  assign bus.frame_start  = r_frame_start;
  assign bus.frame_count  = r_frame_count;
  assign bus.window_valid = r_window_valid;

endmodule

// File: tb/tb_edge_filter_ctrl.sv
// Randomized scoreboard bench for edge_filter_ctrl with compressed frame timing.
module tb_edge_filter_ctrl;

  localparam int H_ACTIVE    = 640;
  localparam int V_ACTIVE    = 480;
  localparam int WIDTH       = 534;
  localparam int HEIGHT      = 400;
  localparam int DC          = 4;
  localparam int THRESH_STEP = 16;
  localparam int HW          = $clog2(H_ACTIVE);
  localparam int VW          = $clog2(V_ACTIVE);
  localparam int N_W         = (H_ACTIVE - WIDTH) / 2;
  localparam int N_H         = (V_ACTIVE - HEIGHT) / 2;

  typedef struct packed {
    logic       fs;
    logic       wv;
    logic [1:0] mode;
    logic [7:0] thr;
    logic [7:0] fc;
  } resp_t;

  logic pixel_clk  = 1'b0;
  logic rst        = 1'b1;
  logic btn_mode   = 1'b0;
  logic btn_thresh = 1'b0;

  edge_filter_ctrl_if #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE)) vif ();

  edge_filter_ctrl #(
    .H_ACTIVE        (H_ACTIVE),
    .V_ACTIVE        (V_ACTIVE),
    .WIDTH           (WIDTH),
    .HEIGHT          (HEIGHT),
    .DEBOUNCE_CYCLES (DC),
    .THRESH_STEP     (THRESH_STEP)
  ) dut (
    .pixel_clk  (pixel_clk),
    .rst        (rst),
    .btn_mode   (btn_mode),
    .btn_thresh (btn_thresh),
    .bus        (vif.slave)
  );

  always #5 pixel_clk = ~pixel_clk;

  resp_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  // Reference model state
  int slot;
  int m_mode, m_thr, m_fc, p_mode, p_thr;
  bit m_warm, m_primed;
  bit m_stab[2];
  int m_run[2];
  int pr_eff[$];
  int pr_btn[$];

  // Random button gesture generator
  bit rand_en;
  bit g_lvl[2];
  int g_left[2];

  task automatic model_reset();
    m_mode = 0; m_thr = 0; m_fc = 0; p_mode = 0; p_thr = 0;
    m_warm = 1'b0; m_primed = 1'b0;
    for (int b = 0; b < 2; b++) begin
      m_stab[b] = 1'b0;
      m_run[b]  = 0;
    end
    pr_eff.delete();
    pr_btn.delete();
  endtask

  task automatic model_step(input int h, input int v, input bit bm, input bit bt,
                            output resp_t e);
    bit lvl[2];
    lvl[0] = bm;
    lvl[1] = bt;
    e = '0;
    // A level is accepted after DC consecutive differing samples; the press then
    // reaches the pending value in time for commits 4 slots after that sample.
    for (int b = 0; b < 2; b++) begin
      if (lvl[b] != m_stab[b]) begin
        m_run[b]++;
        if (m_run[b] == DC) begin
          m_stab[b] = lvl[b];
          m_run[b]  = 0;
          if (lvl[b]) begin
            pr_eff.push_back(slot + 4);
            pr_btn.push_back(b);
          end
        end
      end else begin
        m_run[b] = 0;
      end
    end
    if (v < N_H || v == N_H + HEIGHT) begin
      m_warm   = 1'b0;
      m_primed = 1'b0;
    end else if (v == N_H) begin
      m_warm = 1'b1;
    end else if (v == N_H + 2 && m_warm) begin
      m_primed = 1'b1;
    end
    e.wv = m_primed && (v >= N_H + 2) && (v < N_H + HEIGHT) &&
           (h >= N_W + 2) && (h < N_W + WIDTH);
    if (h == 0 && v == 0) begin
      while (pr_eff.size() > 0 && pr_eff[0] <= slot) begin
        if (pr_btn[0] == 0) p_mode = (p_mode + 1) % 4;
        else                p_thr  = (p_thr + THRESH_STEP) % 256;
        void'(pr_eff.pop_front());
        void'(pr_btn.pop_front());
      end
      m_mode = p_mode;
      m_thr  = p_thr;
      m_fc   = (m_fc + 1) % 256;
      e.fs   = 1'b1;
    end
    e.mode = 2'(m_mode);
    e.thr  = 8'(m_thr);
    e.fc   = 8'(m_fc);
  endtask

  task automatic drive_slot(input int h, input int v, input bit bm, input bit bt,
                            input bit r);
    resp_t e;
    @(negedge pixel_clk);
    rst        = r;
    btn_mode   = bm;
    btn_thresh = bt;
    vif.h_pos  = HW'(h);
    vif.v_pos  = VW'(v);
    if (r) begin
      model_reset();
      e = '0;
    end else begin
      model_step(h, v, bm, bt, e);
    end
    exp_q.push_back(e);
    slot++;
  endtask

  task automatic gen_btn(input int b, output bit lvl);
    if (g_left[b] == 0) begin
      if (g_lvl[b]) begin
        g_lvl[b]  = 1'b0;
        g_left[b] = int'($urandom_range(DC + 12, DC + 3));
      end else begin
        case ($urandom_range(3, 0))
          0: begin
            g_lvl[b]  = 1'b1;
            g_left[b] = int'($urandom_range(DC - 1, 1));
          end
          1, 2: begin
            g_lvl[b]  = 1'b1;
            g_left[b] = int'($urandom_range(DC + 8, DC + 1));
          end
          default: g_left[b] = int'($urandom_range(20, 1));
        endcase
      end
    end
    g_left[b]--;
    lvl = g_lvl[b];
  endtask

  task automatic slot_auto(input int h, input int v);
    bit bm, bt;
    bm = 1'b0;
    bt = 1'b0;
    if (rand_en) begin
      gen_btn(0, bm);
      gen_btn(1, bt);
    end
    drive_slot(h, v, bm, bt, 1'b0);
  endtask

  // One frame with only the lines/columns that matter to the control block.
  task automatic drive_frame(input bit full, input bit rst_mid);
    int lines[$];
    int hs[$];
    lines.push_back(0);
    lines.push_back(int'($urandom_range(N_H - 2, 1)));
    lines.push_back(N_H - 1);
    lines.push_back(N_H);
    lines.push_back(N_H + 1);
    lines.push_back(N_H + 2);
    lines.push_back(N_H + 3);
    lines.push_back(rst_mid ? 250 : int'($urandom_range(N_H + HEIGHT - 2, N_H + 4)));
    lines.push_back(N_H + HEIGHT - 1);
    lines.push_back(N_H + HEIGHT);
    lines.push_back(N_H + HEIGHT + 1);
    lines.push_back(int'($urandom_range(V_ACTIVE - 1, N_H + HEIGHT + 2)));
    lines.push_back(V_ACTIVE + 5);
    foreach (lines[li]) begin
      hs.delete();
      if (full) begin
        for (int h = 0; h < H_ACTIVE; h++) hs.push_back(h);
      end else begin
        hs.push_back(0);
        hs.push_back(1);
        hs.push_back(N_W + 1);
        hs.push_back(N_W + 2);
        hs.push_back(int'($urandom_range(H_ACTIVE + 50, 1)));
        hs.push_back(int'($urandom_range(H_ACTIVE + 50, 1)));
        hs.push_back(N_W + WIDTH - 1);
        hs.push_back(N_W + WIDTH);
        hs.push_back(H_ACTIVE - 1);
        hs.push_back(H_ACTIVE + 20);
      end
      foreach (hs[hi]) slot_auto(hs[hi], lines[li]);
      if (rst_mid && lines[li] == 250) begin
        repeat (2) drive_slot(300, 250, 1'b0, 1'b0, 1'b1);
      end
    end
  endtask

  // Monitor: one expected response per driven slot, sampled after the next rising edge.
  initial begin
    resp_t e, got;
    int    mslot;
    mslot = 0;
    forever begin
      @(posedge pixel_clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {vif.frame_start, vif.window_valid, vif.mode, vif.threshold, vif.frame_count};
        n_vec++;
        if (got !== e) begin
          n_err++;
          $display("FAIL outputs slot %0d: got fs=%0b wv=%0b mode=%0d thr=%0d fc=%0d, expected fs=%0b wv=%0b mode=%0d thr=%0d fc=%0d",
                   mslot, got.fs, got.wv, got.mode, got.thr, got.fc,
                   e.fs, e.wv, e.mode, e.thr, e.fc);
        end
        mslot++;
      end
    end
  end

  initial begin
    slot      = 0;
    rand_en   = 1'b0;
    vif.h_pos = '0;
    vif.v_pos = '0;
    for (int b = 0; b < 2; b++) begin
      g_lvl[b]  = 1'b0;
      g_left[b] = 0;
    end
    model_reset();

    repeat (3) drive_slot(5, 470, 1'b0, 1'b0, 1'b1);
    repeat (4) drive_slot(5, 470, 1'b0, 1'b0, 1'b0);

    // Short glitch must be rejected, long hold accepted once
    repeat (3)  drive_slot(5, 470, 1'b1, 1'b0, 1'b0);
    repeat (12) drive_slot(5, 470, 1'b0, 1'b0, 1'b0);
    drive_frame(1'b0, 1'b0);
    repeat (8)  drive_slot(5, 470, 1'b1, 1'b0, 1'b0);
    repeat (12) drive_slot(5, 470, 1'b0, 1'b0, 1'b0);
    drive_frame(1'b0, 1'b0);

    // Press pulse timed onto the commit cycle of the next frame
    repeat (DC + 2) drive_slot(5, 470, 1'b1, 1'b0, 1'b0);
    drive_frame(1'b0, 1'b0);
    drive_frame(1'b0, 1'b0);

    // Full-width sweep of the window boundary lines
    drive_frame(1'b1, 1'b0);

    for (int f = 0; f < 300; f++) begin
      if (f == 20) begin
        rand_en = 1'b0;
        for (int b = 0; b < 2; b++) begin
          g_lvl[b]  = 1'b0;
          g_left[b] = 0;
        end
        drive_frame(1'b0, 1'b1);
        rand_en = 1'b1;
      end else begin
        rand_en = 1'b1;
        drive_frame(1'b0, 1'b0);
      end
    end
    rand_en = 1'b0;
    repeat (4) drive_slot(5, 470, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge pixel_clk);
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d responses still outstanding, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
